// File: rtl/cache_ctrl.sv
// Direct-mapped, read-only cache controller. Tags and data live in external
// synchronous RAMs (1-cycle read latency); the valid bits live here so a flush
// is a single-cycle clear.
module cache_ctrl #(
    parameter int unsigned TAG_WIDTH   = 25,
    parameter int unsigned INDEX_WIDTH = 7,
    parameter int unsigned CACHE_LINES = 128,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    // CPU side
    input  logic                             cpu_req,
    input  logic [TAG_WIDTH+INDEX_WIDTH-1:0] cpu_addr,
    output logic                             cpu_ready,
    output logic                             cpu_rvalid,
    output logic [DATA_WIDTH-1:0]            cpu_rdata,
    // Invalidate-all
    input  logic                             flush,
    output logic                             flush_done,
    // Refill memory
    output logic                             mem_req,
    output logic [TAG_WIDTH+INDEX_WIDTH-1:0] mem_addr,
    input  logic                             mem_ack,
    input  logic [DATA_WIDTH-1:0]            mem_rdata,
    // Tag / data RAMs
    output logic [INDEX_WIDTH-1:0]           ram_index,
    output logic [TAG_WIDTH-1:0]             tag_wdata,
    output logic                             tag_we,
    input  logic [TAG_WIDTH-1:0]             tag_rdata,
    output logic [DATA_WIDTH-1:0]            data_wdata,
    output logic                             data_we,
    input  logic [DATA_WIDTH-1:0]            data_rdata,
    // Statistics
    output logic [CNT_WIDTH-1:0]             hit_cnt,
    output logic [CNT_WIDTH-1:0]             miss_cnt
);

    localparam int unsigned AW = TAG_WIDTH + INDEX_WIDTH;

    typedef enum logic [1:0] {StIdle, StLookup, StRefill, StResp} state_e;

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [AW-1:0]          r_addr;
    logic [CACHE_LINES-1:0] r_valid;
    logic [DATA_WIDTH-1:0]  r_rdata;
    logic                   r_flush_done;
    logic [CNT_WIDTH-1:0]   r_hit_cnt;
    logic [CNT_WIDTH-1:0]   r_miss_cnt;

    logic [INDEX_WIDTH-1:0] w_idx;
    logic [TAG_WIDTH-1:0]   w_tag;
    logic                   w_hit;
    logic                   w_accept;
    logic                   w_flush;
    logic                   w_lookup_hit;
    logic                   w_lookup_miss;
    logic                   w_ack;

    assign w_idx         = r_addr[INDEX_WIDTH-1:0];
    assign w_tag         = r_addr[AW-1:INDEX_WIDTH];
    assign w_hit         = r_valid[w_idx] && (tag_rdata == w_tag);
    // Flush wins over a simultaneous request; the request is simply not accepted.
    assign w_flush       = (r_state == StIdle) && flush;
    assign w_accept      = (r_state == StIdle) && cpu_req && !flush;
    assign w_lookup_hit  = (r_state == StLookup) && w_hit;
    assign w_lookup_miss = (r_state == StLookup) && !w_hit;
    // A refill ack coinciding with reset must not write the RAMs.
    assign w_ack         = (r_state == StRefill) && mem_ack && !rst;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:   if (w_accept) w_state_nxt = StLookup;
            StLookup: w_state_nxt = w_hit ? StIdle : StRefill;
            StRefill: if (mem_ack) w_state_nxt = StResp;
            StResp:   w_state_nxt = StIdle;
            default:  w_state_nxt = StIdle;
        endcase
    end

    // Address latch, valid vector, returned-data hold register and statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= '0;
            r_valid      <= '0;
            r_rdata      <= '0;
            r_flush_done <= 1'b0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
        end else begin
            r_flush_done <= w_flush;
            if (w_accept) begin
                r_addr <= cpu_addr;
            end
            if (w_flush) begin
                r_valid <= '0;
            end else if (w_ack) begin
                r_valid[w_idx] <= 1'b1;
            end
            if (w_lookup_hit) begin
                r_rdata <= data_rdata;
            end else if (w_ack) begin
                r_rdata <= mem_rdata;
            end
            if (w_lookup_hit && (r_hit_cnt != {CNT_WIDTH{1'b1}})) begin
                r_hit_cnt <= r_hit_cnt + CNT_WIDTH'(1);
            end
            if (w_lookup_miss && (r_miss_cnt != {CNT_WIDTH{1'b1}})) begin
                r_miss_cnt <= r_miss_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Output decode from current state
    always_comb begin
        cpu_ready  = 1'b0;
        cpu_rvalid = 1'b0;
        cpu_rdata  = r_rdata;
        mem_req    = 1'b0;
        mem_addr   = r_addr;
        ram_index  = w_idx;
        tag_wdata  = w_tag;
        tag_we     = 1'b0;
        data_wdata = mem_rdata;
        data_we    = 1'b0;
        case (r_state)
            StIdle: begin
                cpu_ready = !flush;
                // Start the RAM read now so tag/data are ready in LOOKUP.
                ram_index = cpu_addr[INDEX_WIDTH-1:0];
            end
            StLookup: begin
                if (w_hit) begin
                    cpu_rvalid = 1'b1;
                    cpu_rdata  = data_rdata;
                end
            end
            StRefill: begin
                mem_req = 1'b1;
                tag_we  = w_ack;
                data_we = w_ack;
            end
            StResp: begin
                cpu_rvalid = 1'b1;
            end
            default: ;
        endcase
    end

    assign flush_done = r_flush_done;
    assign hit_cnt    = r_hit_cnt;
    assign miss_cnt   = r_miss_cnt;

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: bench-side tag/data RAMs, a
// transaction-level cache model, and a per-cycle compare process.
module tb_cache_ctrl;

    localparam int unsigned TW   = 25;
    localparam int unsigned IW   = 7;
    localparam int unsigned NL   = 128;
    localparam int unsigned DW   = 32;
    localparam int unsigned CW   = 2;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req;
    logic [31:0]   cpu_addr;
    logic          cpu_ready, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          flush, flush_done;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic [IW-1:0] ram_index;
    logic [TW-1:0] tag_wdata, tag_rdata;
    logic          tag_we, data_we;
    logic [DW-1:0] data_wdata, data_rdata;
    logic [CW-1:0] hit_cnt, miss_cnt;

    cache_ctrl #(
        .TAG_WIDTH  (TW),
        .INDEX_WIDTH(IW),
        .CACHE_LINES(NL),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_ready (cpu_ready),
        .cpu_rvalid(cpu_rvalid),
        .cpu_rdata (cpu_rdata),
        .flush     (flush),
        .flush_done(flush_done),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ram_index (ram_index),
        .tag_wdata (tag_wdata),
        .tag_we    (tag_we),
        .tag_rdata (tag_rdata),
        .data_wdata(data_wdata),
        .data_we   (data_we),
        .data_rdata(data_rdata),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous RAMs, read-before-write
    logic [TW-1:0] tag_mem  [NL];
    logic [DW-1:0] data_mem [NL];
    always @(posedge clk) begin
        tag_rdata  <= tag_mem[ram_index];
        data_rdata <= data_mem[ram_index];
        if (tag_we)  tag_mem[ram_index]  <= tag_wdata;
        if (data_we) data_mem[ram_index] <= data_wdata;
    end

    // Cache contents model
    bit            m_valid [NL];
    logic [TW-1:0] m_tag   [NL];
    logic [DW-1:0] m_word  [NL];
    int unsigned   m_hits, m_miss;

    // Per-cycle expectations
    bit            chk_en, pend_fdone;
    bit            e_ready, e_rvalid, e_mem_req, e_we, e_fdone, e_idx_chk;
    logic [DW-1:0] e_rdata;
    logic [31:0]   e_mem_addr;
    logic [IW-1:0] e_index;
    logic [TW-1:0] e_tag;
    logic [DW-1:0] e_wdata;
    int unsigned   n_total, n_bad, we_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cpu_ready", cpu_ready, e_ready);
            chk("cpu_rvalid", cpu_rvalid, e_rvalid);
            chk("cpu_rdata", cpu_rdata, e_rdata);
            chk("mem_req", mem_req, e_mem_req);
            chk("tag_we", tag_we, e_we);
            chk("data_we", data_we, e_we);
            chk("flush_done", flush_done, e_fdone);
            chk("hit_cnt", hit_cnt, m_hits);
            chk("miss_cnt", miss_cnt, m_miss);
            if (e_mem_req) chk("mem_addr", mem_addr, e_mem_addr);
            if (e_we) begin
                chk("wr_index", ram_index, e_index);
                chk("tag_wdata", tag_wdata, e_tag);
                chk("data_wdata", data_wdata, e_wdata);
            end
            if (e_idx_chk) chk("rd_index", ram_index, e_index);
            if (tag_we) we_cnt++;
        end
    end

    function automatic int unsigned sat(input int unsigned v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Set this cycle's expectations, then advance to just after the next edge.
    task automatic cyc(input bit rdy, input bit rv, input bit mreq, input bit we);
        e_ready    = rdy;
        e_rvalid   = rv;
        e_mem_req  = mreq;
        e_we       = we;
        e_fdone    = pend_fdone;
        pend_fdone = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        cpu_req = 0;
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++) m_valid[i] = 0;
        m_hits  = 0;
        m_miss  = 0;
        e_rdata = '0;
    endtask

    // Noise drives flush/cpu_req randomly while busy; both must be ignored.
    task automatic noise_in(input bit noise);
        if (noise) begin
            flush    = 1'($urandom);
            cpu_req  = 1'($urandom);
            cpu_addr = $urandom;
        end else begin
            flush   = 0;
            cpu_req = 0;
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input int ack_dly, input logic [DW-1:0] word,
                           input bit noise, output bit was_hit);
        logic [IW-1:0] idx;
        logic [TW-1:0] tg;
        idx     = addr[IW-1:0];
        tg      = addr[31:IW];
        was_hit = m_valid[idx] && (m_tag[idx] == tg);
        cpu_req   = 1;
        cpu_addr  = addr;
        flush     = 0;
        e_index   = idx;
        e_idx_chk = 1;
        cyc(1, 0, 0, 0);
        e_idx_chk = 0;
        noise_in(noise);
        if (was_hit) begin
            e_rdata = m_word[idx];
            cyc(0, 1, 0, 0);
            m_hits = sat(m_hits);
        end else begin
            cyc(0, 0, 0, 0);
            m_miss     = sat(m_miss);
            e_mem_addr = addr;
            for (int k = 0; k < ack_dly; k++) begin
                noise_in(noise);
                mem_rdata = $urandom;
                cyc(0, 0, 1, 0);
            end
            noise_in(noise);
            mem_ack   = 1;
            mem_rdata = word;
            e_index   = idx;
            e_tag     = tg;
            e_wdata   = word;
            cyc(0, 0, 1, 1);
            mem_ack      = 0;
            mem_rdata    = $urandom;
            m_valid[idx] = 1;
            m_tag[idx]   = tg;
            m_word[idx]  = word;
            e_rdata      = word;
            noise_in(noise);
            cyc(0, 1, 0, 0);
        end
        flush   = 0;
        cpu_req = 0;
    endtask

    // One flush cycle in IDLE, optionally with a competing request.
    task automatic do_flush(input bit with_req, input logic [31:0] addr);
        flush    = 1;
        cpu_req  = with_req;
        cpu_addr = addr;
        cyc(0, 0, 0, 0);
        flush = 0;
        for (int i = 0; i < NL; i++) m_valid[i] = 0;
        pend_fdone = 1;
    endtask

    task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk(name, act, exp);
    endtask

    bit          h;
    int unsigned we_snap;

    initial begin
        for (int i = 0; i < NL; i++) begin
            tag_mem[i]  = '0;
            data_mem[i] = '0;
        end
        n_total = 0; n_bad = 0; we_cnt = 0;
        chk_en = 0; pend_fdone = 0; e_idx_chk = 0;
        e_mem_addr = '0; e_index = '0; e_tag = '0; e_wdata = '0;
        rst = 1; cpu_req = 0; cpu_addr = '0; flush = 0; mem_ack = 0; mem_rdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1;
        cyc(1, 0, 0, 0);
        rst = 0;
        lit("reset_ready", cpu_ready, 1);
        lit("reset_rdata", cpu_rdata, 0);
        idle(1);

        // Cold miss, ack after 3 refill cycles
        do_read(32'h0000_0005, 3, 32'hDEAD_BEEF, 0, h);
        lit("cold_was_hit", h, 0);
        lit("cold_miss_cnt", miss_cnt, 1);
        lit("cold_rdata", cpu_rdata, 32'hDEAD_BEEF);
        lit("cold_we_cnt", we_cnt, 1);
        lit("cold_data_ram5", data_mem[5], 32'hDEAD_BEEF);

        // Hit, back-to-back after the response
        do_read(32'h0000_0005, 0, 32'h0, 0, h);
        lit("hit_was_hit", h, 1);
        lit("hit_cnt_1", hit_cnt, 1);
        lit("hit_rdata", cpu_rdata, 32'hDEAD_BEEF);

        // Conflict on index 5
        do_read(32'h0000_0085, 0, 32'h1234_5678, 0, h);
        lit("conf_was_hit", h, 0);
        lit("conf_tag_ram5", tag_mem[5], 1);
        do_read(32'h0000_0005, 1, 32'hDEAD_BEEF, 0, h);
        lit("conf_again_miss", h, 0);
        lit("conf_miss_cnt", miss_cnt, 3);

        // Saturation: five more hits
        for (int i = 0; i < 5; i++) do_read(32'h0000_0005, 0, 32'h0, 0, h);
        lit("sat_hit_cnt", hit_cnt, 3);

        // Flush with a competing request; the request is taken the next cycle
        do_flush(1, 32'h0000_0005);
        do_read(32'h0000_0005, 2, 32'hA5A5_0005, 0, h);
        lit("flush_then_miss", h, 0);
        idle(2);

        // Reset while refilling, then a late ack
        cpu_req   = 1;
        cpu_addr  = 32'h0000_0011;
        e_index   = 7'h11;
        e_idx_chk = 1;
        cyc(1, 0, 0, 0);
        e_idx_chk = 0;
        cpu_req   = 0;
        cyc(0, 0, 0, 0);
        m_miss     = sat(m_miss);
        e_mem_addr = 32'h0000_0011;
        cyc(0, 0, 1, 0);
        we_snap = we_cnt;
        rst = 1;
        cyc(0, 0, 1, 0);
        rst = 0;
        model_reset();
        mem_ack   = 1;
        mem_rdata = 32'hCAFE_F00D;
        cyc(1, 0, 0, 0);
        mem_ack = 0;
        lit("rst_hit_cnt", hit_cnt, 0);
        lit("rst_miss_cnt", miss_cnt, 0);
        lit("rst_rdata", cpu_rdata, 0);
        lit("rst_no_write", we_cnt, we_snap);
        lit("rst_data_ram17", data_mem[17], 0);
        do_read(32'h0000_0005, 0, 32'h0BAD_0005, 0, h);
        lit("rst_valid_clear", h, 0);

        // Randomized traffic over a small address pool
        for (int i = 0; i < 300; i++) begin
            int unsigned r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            a = {7'd0, 25'($urandom_range(0, 3)), 7'($urandom_range(0, 7))} >> 7;
            a = {a[24:0], 7'($urandom_range(0, 7))};
            if (r == 0) begin
                do_flush(1'($urandom), a);
            end else if (r == 1) begin
                idle($urandom_range(1, 3));
            end else begin
                do_read(a, $urandom_range(0, 4), $urandom, 1'($urandom), h);
            end
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
